// File: rtl/cpu_pipe_pkg.sv
// Shared ID/EX types and width defaults
// for the 16-bit pipelined CPU.
package cpu_pipe_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_ALU_OP_W   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DEF_ALU_OP_W-1:0] alu_op;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]     reg_data1;
    logic [DEF_DATA_W-1:0]     reg_data2;
    logic [DEF_DATA_W-1:0]     imm;
    logic [DEF_REG_ADDR_W-1:0] rd;
    id_ex_ctrl_t               ctrl;
  } id_ex_payload_t;

  function automatic int payload_w(
    input int dw,
    input int rw,
    input int aw
  );
    return 3*dw + rw + aw + 3;
  endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-slot skid buffer: main slot drives the output,
// skid slot catches the one beat accepted during a stall.
module pipe_skid_buffer
  import cpu_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_acc;
  logic         w_drn;

  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign w_acc     = in_valid & in_ready;
  assign w_drn     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main  <= in_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            r_main <= in_data;
          end else if (w_acc) begin
            r_skid  <= in_data;
            r_state <= ST_TWO;
          end else if (w_drn) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drn) begin
            r_main  <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX stage: skid-buffered payload, control gated
// on out_valid, saturating stall counter.
module id_ex_pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALU_OP_W   = DEF_ALU_OP_W,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     reg_data1_in,
  input  logic [DATA_W-1:0]     reg_data2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [ALU_OP_W-1:0]   alu_op_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     reg_data1_out,
  output logic [DATA_W-1:0]     reg_data2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [ALU_OP_W-1:0]   alu_op_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [STAT_W-1:0]     stall_count
);

  localparam int PW =
    payload_w(DATA_W, REG_ADDR_W, ALU_OP_W);
  localparam logic [STAT_W-1:0] ONE_C =
    {{(STAT_W-1){1'b0}}, 1'b1};

  logic [PW-1:0]     w_in;
  logic [PW-1:0]     w_out;
  logic              w_rw;
  logic              w_mr;
  logic              w_mw;
  logic [STAT_W-1:0] r_stall;

  assign w_in = {reg_data1_in, reg_data2_in, imm_in,
                 rd_in, alu_op_in,
                 reg_write_in, mem_read_in, mem_write_in};

  pipe_skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign {reg_data1_out, reg_data2_out, imm_out,
          rd_out, alu_op_out,
          w_rw, w_mr, w_mw} = w_out;

  // Bubbles must never write state downstream.
  assign reg_write_out = w_rw & out_valid;
  assign mem_read_out  = w_mr & out_valid;
  assign mem_write_out = w_mw & out_valid;

  assign stall_count = r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && !(&r_stall)) begin
      r_stall <= r_stall + ONE_C;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Randomized self-checking bench for id_ex_pipe_stage
// against a queue-based reference model.
module tb_id_ex_pipe_stage;

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [3:0]  alu;
    logic        rw;
    logic        mr;
    logic        mw;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d1_i, d2_i, imm_i;
  logic [3:0]  rd_i, alu_i;
  logic        rw_i, mr_i, mw_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d1_o, d2_o, imm_o;
  logic [3:0]  rd_o, alu_o;
  logic        rw_o, mr_o, mw_o;
  logic [3:0]  stall_count;

  int checks = 0;
  int failures = 0;

  ins_t q[$];
  ins_t last = '0;
  int   stall_m = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(
    .DATA_W(16), .REG_ADDR_W(4), .ALU_OP_W(4), .STAT_W(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .reg_data1_in  (d1_i),
    .reg_data2_in  (d2_i),
    .imm_in        (imm_i),
    .rd_in         (rd_i),
    .alu_op_in     (alu_i),
    .reg_write_in  (rw_i),
    .mem_read_in   (mr_i),
    .mem_write_in  (mw_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .reg_data1_out (d1_o),
    .reg_data2_out (d2_o),
    .imm_out       (imm_o),
    .rd_out        (rd_o),
    .alu_op_out    (alu_o),
    .reg_write_out (rw_o),
    .mem_read_out  (mr_o),
    .mem_write_out (mw_o),
    .stall_count   (stall_count)
  );

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Reference: a bounded FIFO of depth two.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last = '0;
      stall_m = 0;
    end else begin
      bit acc, drn;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready && stall_m < 15)
        stall_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc)
          q.push_back('{d1_i, d2_i, imm_i, rd_i, alu_i,
                        rw_i, mr_i, mw_i});
      end
      if (q.size() > 0) last = q[0];
    end
  end

  always @(negedge clk) begin
    bit v;
    v = (q.size() > 0);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("payload", 64'({d1_o, d2_o, imm_o, rd_o, alu_o}),
        64'({last.d1, last.d2, last.imm, last.rd, last.alu}));
    chk("ctrl", 64'({rw_o, mr_o, mw_o}),
        64'({last.rw & v, last.mr & v, last.mw & v}));
    chk("stall_count", 64'(stall_count), 64'(stall_m));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] rd,
                        input logic [3:0] alu, input logic rw,
                        input logic mr, input logic mw);
    in_valid = v;
    rd_i = rd;
    alu_i = alu;
    rw_i = rw;
    mr_i = mr;
    mw_i = mw;
    d1_i = 16'($urandom);
    d2_i = 16'($urandom);
    imm_i = 16'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_rd", 64'(rd_o), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    reset = 1'b0;
    step();

    // streaming
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 4'(i), 4'h2, 1'b1, 1'b0, 1'b0);
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_rd", 64'(rd_o), 64'(i));
      chk("stream_alu", 64'(alu_o), 64'h2);
    end
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("stream_stall", 64'(stall_count), 64'd0);

    // back-pressure
    set_in(1'b1, 4'd5, 4'h1, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    set_in(1'b1, 4'd6, 4'h1, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_rd_hold", 64'(rd_o), 64'd5);
    set_in(1'b1, 4'd7, 4'h1, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    chk("bp_rd_hold2", 64'(rd_o), 64'd5);
    chk("bp_stall", 64'(stall_count), 64'd3);
    out_ready = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_rd_next", 64'(rd_o), 64'd6);
    chk("bp_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_stall_end", 64'(stall_count), 64'd3);

    // flush in TWO
    out_ready = 1'b0;
    set_in(1'b1, 4'd8, 4'h3, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 4'd9, 4'h3, 1'b0, 1'b0, 1'b0);
    step();
    chk("fl_two", 64'(in_ready), 64'd0);
    flush = 1'b1;
    set_in(1'b1, 4'd10, 4'h3, 1'b1, 1'b0, 1'b0);
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rw", 64'(rw_o), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_stall", 64'(stall_count), 64'd5);
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step();
      chk("fl_never", 64'(out_valid), 64'd0);
    end

    // bubble gating
    set_in(1'b1, 4'd11, 4'h4, 1'b0, 1'b0, 1'b1);
    step();
    chk("bub_mw_on", 64'(mw_o), 64'd1);
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bub_valid", 64'(out_valid), 64'd0);
    chk("bub_mw_off", 64'(mw_o), 64'd0);
    chk("bub_rd_kept", 64'(rd_o), 64'd11);

    // saturation
    out_ready = 1'b0;
    set_in(1'b1, 4'd12, 4'h5, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat_stall", 64'(stall_count), 64'd15);
    out_ready = 1'b1;
    step();

    // async reset in TWO
    out_ready = 1'b0;
    set_in(1'b1, 4'd13, 4'h6, 1'b1, 1'b1, 1'b1);
    step();
    set_in(1'b1, 4'd14, 4'h6, 1'b1, 1'b1, 1'b1);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_rd", 64'(rd_o), 64'd0);
    chk("ar_ctrl", 64'({rw_o, mr_o, mw_o}), 64'd0);
    chk("ar_stall", 64'(stall_count), 64'd0);
    step();
    reset = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in(1'(($urandom % 4) != 0), 4'($urandom),
             4'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
      out_ready = 1'(($urandom % 3) != 0);
      flush = 1'(($urandom % 20) == 0);
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
